// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states and default
// widths / bubble instruction used by the fetch controller.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // sll $0,$0,0 -- presented to decode whenever no instruction is held
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one word read per PC over req/gnt/rvalid,
// result handed to decode over valid/ready, with flush and misalign handling.
module ifetch_ctrl
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              pc_en_o,
  output logic              misalign_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  // a flush arrived while the request was still waiting for its grant
  logic              flush_pend_q, flush_pend_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    valid_d      = valid_q;
    misalign_d   = misalign_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      IDLE: begin
        // a flush means pc_i is stale this cycle, so wait for the new target
        if (!flush_i && !misalign_q) begin
          if (pc_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = {pc_i[ADDR_W-1:2], 2'b00};
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (imem_gnt_i) begin
          flush_pend_d = 1'b0;
          if (flush_i || flush_pend_q) begin
            state_d = DRAIN;
          end else begin
            ipc_d   = addr_q;
            state_d = WAIT;
          end
        end else if (flush_i) begin
          flush_pend_d = 1'b1;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = imem_rvalid_i ? IDLE : DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (flush_i || instr_ready_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      instr_q      <= NOP_INSTR;
      ipc_q        <= '0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;
  assign misalign_o    = misalign_q;
  assign pc_en_o       = (valid_q & instr_ready_i) | flush_i;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: vector table, directed corner cases,
// then random traffic against a PC/memory reference model.
module tb_ifetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        valid;
  logic        ready;
  logic        pc_en;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;

  ifetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .flush_i       (flush),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .pc_en_o       (pc_en),
    .misalign_o    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_pcen;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] p, input logic f, input logic g,
                        input logic rv, input logic [31:0] rd, input logic rdy);
    pc = p; flush = f; gnt = g; rvalid = rv; rdata = rd; ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},      req,      0);
    chk({tag, "_addr"},     addr,     0);
    chk({tag, "_instr"},    instr,    NOP);
    chk({tag, "_ipc"},      ipc,      0);
    chk({tag, "_valid"},    valid,    0);
    chk({tag, "_misalign"}, misalign, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic g, input logic rv,
                              input logic [31:0] rd, input logic rdy, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] einstr, input logic [31:0] eipc,
                              input logic epcen);
    vec_t v;
    v.pc = p; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid;
    v.e_instr = einstr; v.e_ipc = eipc; v.e_pcen = epcen;
    return v;
  endfunction

  // contents of the random-test instruction memory
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // random-phase model state
  logic [31:0] pc_reg;
  logic [31:0] tgt;
  logic [31:0] mem_data;
  logic [31:0] prev_addr;
  logic        mem_pend;
  logic        stall_prev;
  int          mem_wait;
  int          accepts;

  initial begin
    // basic fetch, grant stall with moving pc_i, then 5 cycles of back-pressure
    tbl[0]  = mk(32'h00, 0, 0, 0,            1, 0, 0,     0, NOP,          0, 0);
    tbl[1]  = mk(32'h00, 1, 0, 0,            1, 1, 32'h0, 0, NOP,          0, 0);
    tbl[2]  = mk(32'h00, 0, 1, 32'h20080005, 1, 0, 0,     0, NOP,          0, 0);
    tbl[3]  = mk(32'h00, 0, 0, 0,            1, 0, 0,     1, 32'h20080005, 0, 1);
    tbl[4]  = mk(32'h04, 0, 0, 0,            1, 0, 0,     0, NOP,          0, 0);
    tbl[5]  = mk(32'h08, 0, 0, 0,            1, 1, 32'h4, 0, NOP,          0, 0);
    tbl[6]  = mk(32'h0C, 0, 0, 0,            1, 1, 32'h4, 0, NOP,          0, 0);
    tbl[7]  = mk(32'h10, 0, 0, 0,            1, 1, 32'h4, 0, NOP,          0, 0);
    tbl[8]  = mk(32'h14, 1, 0, 0,            1, 1, 32'h4, 0, NOP,          0, 0);
    tbl[9]  = mk(32'h04, 0, 0, 0,            1, 0, 0,     0, NOP,          0, 0);
    tbl[10] = mk(32'h04, 0, 1, 32'h8C010004, 0, 0, 0,     0, NOP,          0, 0);
    for (int i = 11; i < 16; i++)
      tbl[i] = mk(32'h04, 0, 0, 0, 0, 0, 0, 1, 32'h8C010004, 32'h4, 0);
    tbl[16] = mk(32'h04, 0, 0, 0,            1, 0, 0,     1, 32'h8C010004, 32'h4, 1);
    tbl[17] = mk(32'h08, 0, 0, 0,            0, 0, 0,     0, NOP,          0, 0);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].pc, 0, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready);
      #1;
      $display("row %0d: req=%0b addr=%h valid=%0b instr=%h ipc=%h pc_en=%0b",
               i, req, addr, valid, instr, ipc, pc_en);
      chk($sformatf("row%0d_req", i),   req,   tbl[i].e_req);
      chk($sformatf("row%0d_valid", i), valid, tbl[i].e_valid);
      chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("row%0d_pc_en", i), pc_en, tbl[i].e_pcen);
      if (tbl[i].e_req)   chk($sformatf("row%0d_addr", i), addr, tbl[i].e_addr);
      if (tbl[i].e_valid) chk($sformatf("row%0d_ipc", i),  ipc,  tbl[i].e_ipc);
      tick();
    end

    // flush in WAIT, late data discarded, refetch from new PC, then flush vs accept
    do_reset();
    set_in(32'h10, 0, 0, 0, 0, 0);
    #1 tick();
    set_in(32'h10, 0, 1, 0, 0, 0);
    #1 chk("wflush_req", req, 1);
    chk("wflush_addr", addr, 32'h10);
    tick();
    set_in(32'h10, 1, 0, 0, 0, 0);
    #1 chk("wflush_pc_en", pc_en, 1);
    tick();
    set_in(32'h40, 0, 0, 1, 32'hDEADBEEF, 0);
    #1 chk("drain_req", req, 0);
    chk("drain_valid", valid, 0);
    tick();
    set_in(32'h40, 0, 0, 0, 0, 0);
    #1 chk("post_drain_valid", valid, 0);
    chk("post_drain_instr", instr, NOP);
    tick();
    #1 chk("refetch_req", req, 1);
    chk("refetch_addr", addr, 32'h40);
    $display("seq flush-in-WAIT: refetch addr=%h", addr);
    set_in(32'h40, 0, 1, 0, 0, 0);
    tick();
    set_in(32'h40, 0, 0, 1, 32'h24020040, 0);
    tick();
    set_in(32'h40, 0, 0, 0, 0, 0);
    #1 chk("refetch_valid", valid, 1);
    chk("refetch_instr", instr, 32'h24020040);
    chk("refetch_ipc", ipc, 32'h40);
    set_in(32'h40, 1, 0, 0, 0, 1);
    #1 chk("flush_acc_pc_en", pc_en, 1);
    tick();
    set_in(32'h80, 0, 0, 0, 0, 0);
    #1 chk("flush_acc_valid", valid, 0);
    chk("flush_acc_instr", instr, NOP);
    chk("flush_acc_req", req, 0);
    tick();
    #1 chk("flush_acc_next_req", req, 1);
    chk("flush_acc_next_addr", addr, 32'h80);
    $display("seq flush-on-accept: next addr=%h", addr);

    // misaligned PC, recovery by flush, then async reset mid-WAIT
    do_reset();
    set_in(32'h6, 0, 0, 0, 0, 0);
    #1 chk("mis_before", misalign, 0);
    tick();
    #1 chk("mis_set", misalign, 1);
    chk("mis_req", req, 0);
    set_in(32'h0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    #1 chk("mis_sticky", misalign, 1);
    chk("mis_no_fetch", req, 0);
    set_in(32'h8, 1, 0, 0, 0, 0);
    #1 chk("mis_flush_pc_en", pc_en, 1);
    tick();
    set_in(32'h8, 0, 0, 0, 0, 0);
    #1 chk("mis_cleared", misalign, 0);
    tick();
    #1 chk("mis_resume_req", req, 1);
    chk("mis_resume_addr", addr, 32'h8);
    $display("seq misalign: resumed at addr=%h", addr);
    set_in(32'h8, 0, 1, 0, 0, 0);
    tick();
    set_in(32'h8, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // random traffic: accepted instructions must match the PC model and memory
    do_reset();
    pc_reg = 0; mem_pend = 0; mem_wait = 0; mem_data = 0;
    stall_prev = 0; prev_addr = 0; accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rvalid = mem_pend && (mem_wait == 0);
      rdata  = rvalid ? mem_data : $urandom;
      gnt    = req && !mem_pend && ($urandom_range(0, 2) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 11) == 0);
      tgt    = 32'($urandom_range(0, 255)) << 2;
      pc     = pc_reg;
      #1;
      chk("rnd_pc_en", pc_en, (valid && ready) || flush);
      if (req && mem_pend) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_overlap: request issued while a read is outstanding at cycle %0d", cyc);
      end
      if (stall_prev) begin
        chk("rnd_req_hold", req, 1);
        chk("rnd_addr_hold", addr, prev_addr);
      end
      if (!valid) chk("rnd_idle_instr", instr, NOP);
      if (valid && ready && !flush) begin
        accepts++;
        $display("accept %0d: pc=%h instr=%h", accepts, ipc, instr);
        chk("rnd_ipc", ipc, pc_reg);
        chk("rnd_instr", instr, memf(pc_reg));
      end
      if (rvalid) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (gnt) begin
        mem_pend = 1'b1;
        mem_wait = $urandom_range(0, 2);
        mem_data = memf(addr);
      end
      stall_prev = req && !gnt;
      prev_addr  = addr;
      if (flush) pc_reg = tgt;
      else if (valid && ready) pc_reg = pc_reg + 4;
      tick();
    end
    chk("rnd_progress", accepts > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
